// File: rtl/snes_bus_sync_if.sv
// SNES cartridge-bus signal bundle between the raw pins/mapper and the
// conditioning stage (slave) and the master FSM side (master).
interface snes_bus_sync_if;
    logic [23:0] snes_addr_in;
    logic        snes_read_in;
    logic        snes_write_in;
    logic        snes_pard_in;
    logic        snes_romsel_in;
    logic        snes_cpu_clk_in;
    logic        rom_hit;

    logic [23:0] snes_addr;
    logic        snes_read;
    logic        snes_write;
    logic        snes_pard;
    logic        snes_romsel;
    logic        snes_cpu_clk;
    logic        rd_start;
    logic        rd_end;
    logic        wr_end;
    logic        pard_start;
    logic        cycle_start;
    logic        cycle_end;
    logic        free_slot;
    logic        snes_dead;
    logic        snes_alive;

    modport slave (
        input  snes_addr_in, snes_read_in, snes_write_in, snes_pard_in,
               snes_romsel_in, snes_cpu_clk_in, rom_hit,
        output snes_addr, snes_read, snes_write, snes_pard, snes_romsel,
               snes_cpu_clk, rd_start, rd_end, wr_end, pard_start,
               cycle_start, cycle_end, free_slot, snes_dead, snes_alive
    );

    modport master (
        output snes_addr_in, snes_read_in, snes_write_in, snes_pard_in,
               snes_romsel_in, snes_cpu_clk_in, rom_hit,
        input  snes_addr, snes_read, snes_write, snes_pard, snes_romsel,
               snes_cpu_clk, rd_start, rd_end, wr_end, pard_start,
               cycle_start, cycle_end, free_slot, snes_dead, snes_alive
    );
endinterface

// File: rtl/snes_bus_sync.sv
// Oversampling front end for the asynchronous SNES bus: glitch-filtered levels,
// edge strobes, free memory slot indication and SNES dead/alive detection.
//
// state    | meaning
// ST_DEAD  | SNES CPU clock stopped (or fresh from reset); snes_dead high
// ST_ALIVE | SNES CPU clock seen high; waiting for a low stretch > DEAD_TIMEOUT
module snes_bus_sync #(
    parameter int unsigned DEAD_TIMEOUT = 96000
) (
    input  logic            clk,
    input  logic            rst_n,
    snes_bus_sync_if.slave  bus
);

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_ALIVE = 1'b1
    } state_t;

    localparam logic [17:0] DEAD_LIMIT = 18'(DEAD_TIMEOUT);
    localparam logic [17:0] CNT_MAX    = '1;

    logic [7:0]        read_r;
    logic [7:0]        write_r;
    logic [7:0]        pard_r;
    logic [7:0]        cpu_clk_r;
    // romsel only ever looks at samples 4 and 5, so older history is not kept
    logic [5:0]        romsel_r;
    logic [6:0][23:0]  addr_q;

    logic [5:0]        rd_or;
    logic [5:0]        rd_and;
    logic [5:0]        wr_and;
    logic [5:0]        pard_or;
    logic [5:0]        clk_and;
    logic [5:0]        clk_or;
    logic              cycle_start_w;
    logic              cycle_end_w;

    state_t            state;
    logic [17:0]       low_cnt;
    logic              free_strobe;
    logic              snes_dead_q;
    logic              snes_alive_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_r    <= '1;
            write_r   <= '1;
            pard_r    <= '1;
            romsel_r  <= '1;
            cpu_clk_r <= '0;
            addr_q    <= '0;
        end else begin
            read_r    <= {read_r[6:0],    bus.snes_read_in};
            write_r   <= {write_r[6:0],   bus.snes_write_in};
            pard_r    <= {pard_r[6:0],    bus.snes_pard_in};
            romsel_r  <= {romsel_r[4:0],  bus.snes_romsel_in};
            cpu_clk_r <= {cpu_clk_r[6:0], bus.snes_cpu_clk_in};
            addr_q    <= {addr_q[5:0],    bus.snes_addr_in};
        end
    end

    // Bit i of each vector pairs samples i+1 and i+2, so r[0] never qualifies an edge
    assign rd_or   = read_r[6:1]    | read_r[7:2];
    assign rd_and  = read_r[6:1]    & read_r[7:2];
    assign wr_and  = write_r[6:1]   & write_r[7:2];
    assign pard_or = pard_r[6:1]    | pard_r[7:2];
    assign clk_and = cpu_clk_r[7:2] & cpu_clk_r[6:1];
    assign clk_or  = cpu_clk_r[7:2] | cpu_clk_r[6:1];

    assign cycle_start_w = (clk_and == 6'b000011);
    assign cycle_end_w   = (clk_or  == 6'b111000);

    assign bus.rd_start    = (rd_or   == 6'b111100);
    assign bus.pard_start  = (pard_or == 6'b111110);
    assign bus.rd_end      = (rd_and  == 6'b000001);
    assign bus.wr_end      = (wr_and  == 6'b000001);
    assign bus.cycle_start = cycle_start_w;
    assign bus.cycle_end   = cycle_end_w;

    assign bus.snes_read    = read_r[2]    & read_r[1];
    assign bus.snes_write   = write_r[2]   & write_r[1];
    assign bus.snes_pard    = pard_r[2]    & pard_r[1];
    assign bus.snes_cpu_clk = cpu_clk_r[2] & cpu_clk_r[1];
    assign bus.snes_romsel  = romsel_r[5]  & romsel_r[4];
    assign bus.snes_addr    = addr_q[6]    & addr_q[5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_DEAD;
            low_cnt      <= '0;
            free_strobe  <= 1'b0;
            snes_dead_q  <= 1'b1;
            snes_alive_q <= 1'b0;
        end else begin
            free_strobe  <= cycle_start_w ? ~bus.rom_hit : 1'b0;
            snes_alive_q <= 1'b0;

            if (cpu_clk_r[1]) begin
                low_cnt <= '0;
            end else if (low_cnt != CNT_MAX) begin
                low_cnt <= low_cnt + 18'd1;
            end

            case (state)
                ST_DEAD: begin
                    if (cpu_clk_r[1]) begin
                        state        <= ST_ALIVE;
                        snes_dead_q  <= 1'b0;
                        snes_alive_q <= 1'b1;
                    end
                end
                ST_ALIVE: begin
                    if (!cpu_clk_r[1] && (low_cnt > DEAD_LIMIT)) begin
                        state       <= ST_DEAD;
                        snes_dead_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_DEAD;
                    snes_dead_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.free_slot  = cycle_end_w | free_strobe;
    assign bus.snes_dead  = snes_dead_q;
    assign bus.snes_alive = snes_alive_q;

endmodule

// File: tb/tb_snes_bus_sync.sv
// Directed bench for snes_bus_sync: timed expectations are queued when stimulus
// is driven and compared on the edge they fall due; pulse counts catch extras.
module tb_snes_bus_sync;

    localparam int unsigned DEAD_T = 20;
    localparam logic [23:0] HI = 24'd1;
    localparam logic [23:0] LO = 24'd0;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    snes_bus_sync_if bus ();

    snes_bus_sync #(.DEAD_TIMEOUT(DEAD_T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {
        S_RD_START = 0, S_RD_END = 1, S_WR_END = 2, S_PARD_START = 3,
        S_CYC_START = 4, S_CYC_END = 5, S_FREE = 6, S_ALIVE = 7,
        S_DEAD = 8, S_READ = 9, S_WRITE = 10, S_PARD = 11,
        S_ROMSEL = 12, S_CPUCLK = 13, S_ADDR = 14
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [23:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          edge_n = 0;
    int          errors = 0;
    int          checks = 0;
    int          cnt  [16] = '{default: 0};
    int          base [16] = '{default: 0};
    logic [23:0] mon_v;

    function automatic logic [23:0] get_sig(sig_e s);
        case (s)
            S_RD_START:   return {23'd0, bus.rd_start};
            S_RD_END:     return {23'd0, bus.rd_end};
            S_WR_END:     return {23'd0, bus.wr_end};
            S_PARD_START: return {23'd0, bus.pard_start};
            S_CYC_START:  return {23'd0, bus.cycle_start};
            S_CYC_END:    return {23'd0, bus.cycle_end};
            S_FREE:       return {23'd0, bus.free_slot};
            S_ALIVE:      return {23'd0, bus.snes_alive};
            S_DEAD:       return {23'd0, bus.snes_dead};
            S_READ:       return {23'd0, bus.snes_read};
            S_WRITE:      return {23'd0, bus.snes_write};
            S_PARD:       return {23'd0, bus.snes_pard};
            S_ROMSEL:     return {23'd0, bus.snes_romsel};
            S_CPUCLK:     return {23'd0, bus.snes_cpu_clk};
            S_ADDR:       return bus.snes_addr;
            default:      return 24'd0;
        endcase
    endfunction

    // Pulse counters for the one-cycle outputs, sampled mid-cycle
    always @(negedge clk) begin
        for (int s = 0; s < 8; s++) begin
            mon_v = get_sig(sig_e'(s));
            if (mon_v[0] === 1'b1) cnt[s] = cnt[s] + 1;
        end
    end

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(int cyc, sig_e s, logic [23:0] v, string tag);
        exp_t e;
        e.cyc = cyc;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == edge_n) begin
                chk(sb[i].tag, get_sig(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic snap();
        base = cnt;
    endtask

    task automatic chk_pulses(string tag, sig_e s, int exp);
        chk(tag, 24'(cnt[int'(s)] - base[int'(s)]), 24'(exp));
    endtask

    task automatic cpu_period(logic hit, string tag);
        int k;
        bus.snes_cpu_clk_in = 1'b1;
        k = edge_n + 1;
        expect_at(k + 2, S_CYC_START, LO, {tag, "_cstart_early"});
        expect_at(k + 3, S_CYC_START, HI, {tag, "_cstart"});
        expect_at(k + 4, S_CYC_START, LO, {tag, "_cstart_width"});
        expect_at(k + 3, S_FREE, LO, {tag, "_free_early"});
        expect_at(k + 4, S_FREE, {23'd0, ~hit}, {tag, "_free_after_cstart"});
        expect_at(k + 5, S_FREE, LO, {tag, "_free_width"});
        run(6);
        bus.snes_cpu_clk_in = 1'b0;
        k = edge_n + 1;
        expect_at(k + 3, S_CYC_END, LO, {tag, "_cend_early"});
        expect_at(k + 4, S_CYC_END, HI, {tag, "_cend"});
        expect_at(k + 5, S_CYC_END, LO, {tag, "_cend_width"});
        expect_at(k + 4, S_FREE, HI, {tag, "_free_on_cend"});
        expect_at(k + 5, S_FREE, LO, {tag, "_free_after_cend"});
        run(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time budget exceeded with %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n               = 1'b0;
        bus.snes_addr_in    = 24'd0;
        bus.snes_read_in    = 1'b1;
        bus.snes_write_in   = 1'b1;
        bus.snes_pard_in    = 1'b1;
        bus.snes_romsel_in  = 1'b1;
        bus.snes_cpu_clk_in = 1'b0;
        bus.rom_hit         = 1'b0;

        // reset state
        expect_at(2, S_READ,      HI, "rst_read");
        expect_at(2, S_WRITE,     HI, "rst_write");
        expect_at(2, S_PARD,      HI, "rst_pard");
        expect_at(2, S_ROMSEL,    HI, "rst_romsel");
        expect_at(2, S_CPUCLK,    LO, "rst_cpu_clk");
        expect_at(2, S_ADDR,      LO, "rst_addr");
        expect_at(2, S_DEAD,      HI, "rst_dead");
        expect_at(2, S_FREE,      LO, "rst_free");
        expect_at(2, S_RD_START,  LO, "rst_rd_start");
        expect_at(2, S_CYC_START, LO, "rst_cycle_start");
        run(2);

        // idle refill after reset
        rst_n = 1'b1;
        snap();
        expect_at(edge_n + 20, S_READ, HI, "idle_read");
        expect_at(edge_n + 20, S_DEAD, HI, "idle_dead");
        run(20);
        for (int s = 0; s < 8; s++) chk_pulses($sformatf("idle_pulses_%0d", s), sig_e'(s), 0);

        // read low for 20 samples
        snap();
        bus.snes_read_in = 1'b0;
        k = edge_n + 1;
        expect_at(k,     S_READ,     HI, "rd_level_before");
        expect_at(k + 1, S_READ,     LO, "rd_level_fall");
        expect_at(k + 2, S_RD_START, LO, "rd_start_early");
        expect_at(k + 3, S_RD_START, HI, "rd_start");
        expect_at(k + 4, S_RD_START, LO, "rd_start_width");
        run(20);
        bus.snes_read_in = 1'b1;
        k = edge_n + 1;
        expect_at(k + 1, S_READ,   LO, "rd_level_rise_early");
        expect_at(k + 2, S_READ,   HI, "rd_level_rise");
        expect_at(k + 1, S_RD_END, LO, "rd_end_early");
        expect_at(k + 2, S_RD_END, HI, "rd_end");
        expect_at(k + 3, S_RD_END, LO, "rd_end_width");
        run(8);
        chk_pulses("rd_start_count", S_RD_START, 1);
        chk_pulses("rd_end_count",   S_RD_END,   1);
        chk_pulses("rd_wr_end_count", S_WR_END,  0);

        // pard and romsel fall/rise together
        snap();
        bus.snes_pard_in   = 1'b0;
        bus.snes_romsel_in = 1'b0;
        k = edge_n + 1;
        expect_at(k + 1, S_PARD,       LO, "pard_level_fall");
        expect_at(k + 1, S_PARD_START, LO, "pard_start_early");
        expect_at(k + 2, S_PARD_START, HI, "pard_start");
        expect_at(k + 3, S_PARD_START, LO, "pard_start_width");
        expect_at(k + 3, S_ROMSEL,     HI, "romsel_fall_early");
        expect_at(k + 4, S_ROMSEL,     LO, "romsel_fall");
        run(8);
        bus.snes_pard_in   = 1'b1;
        bus.snes_romsel_in = 1'b1;
        k = edge_n + 1;
        expect_at(k + 1, S_PARD,   LO, "pard_rise_early");
        expect_at(k + 2, S_PARD,   HI, "pard_rise");
        expect_at(k + 4, S_ROMSEL, LO, "romsel_rise_early");
        expect_at(k + 5, S_ROMSEL, HI, "romsel_rise");
        run(8);
        chk_pulses("pard_start_count", S_PARD_START, 1);
        chk_pulses("pard_rd_start_count", S_RD_START, 0);

        // write: low glitch, sustained low with high glitch, clean release
        snap();
        bus.snes_write_in = 1'b0;
        run(1);
        bus.snes_write_in = 1'b1;
        run(10);
        chk_pulses("wr_low_glitch_count", S_WR_END, 0);
        bus.snes_write_in = 1'b0;
        k = edge_n + 1;
        expect_at(k + 1, S_WRITE, LO, "wr_level_fall");
        run(5);
        bus.snes_write_in = 1'b1;
        k = edge_n + 1;
        for (int i = 0; i < 9; i++) expect_at(k + i, S_WRITE, LO, $sformatf("wr_high_glitch_level_%0d", i));
        run(1);
        bus.snes_write_in = 1'b0;
        run(9);
        chk_pulses("wr_glitch_count", S_WR_END, 0);
        bus.snes_write_in = 1'b1;
        k = edge_n + 1;
        expect_at(k + 1, S_WR_END, LO, "wr_end_early");
        expect_at(k + 2, S_WR_END, HI, "wr_end");
        expect_at(k + 3, S_WR_END, LO, "wr_end_width");
        expect_at(k + 2, S_WRITE,  HI, "wr_level_rise");
        run(6);
        chk_pulses("wr_end_count", S_WR_END, 1);

        // cpu clock 6 high / 6 low, rom_hit low then high
        snap();
        bus.rom_hit = 1'b0;
        for (int p = 0; p < 3; p++) cpu_period(1'b0, $sformatf("miss%0d", p));
        chk_pulses("miss_cstart_count", S_CYC_START, 3);
        chk_pulses("miss_cend_count",   S_CYC_END,   3);
        chk_pulses("miss_free_count",   S_FREE,      6);
        chk_pulses("miss_alive_count",  S_ALIVE,     1);
        snap();
        bus.rom_hit = 1'b1;
        for (int p = 0; p < 3; p++) cpu_period(1'b1, $sformatf("hit%0d", p));
        chk_pulses("hit_cstart_count", S_CYC_START, 3);
        chk_pulses("hit_free_count",   S_FREE,      3);
        chk_pulses("hit_alive_count",  S_ALIVE,     0);
        bus.rom_hit = 1'b0;

        // dead detection
        bus.snes_cpu_clk_in = 1'b1;
        run(6);
        snap();
        bus.snes_cpu_clk_in = 1'b0;
        k = edge_n + 1;
        expect_at(k + 1 + DEAD_T + 1, S_DEAD, LO, "dead_early");
        expect_at(k + 1 + DEAD_T + 2, S_DEAD, HI, "dead_set");
        run(30);
        bus.snes_cpu_clk_in = 1'b1;
        k = edge_n + 1;
        expect_at(k + 1, S_DEAD,  HI, "dead_hold");
        expect_at(k + 1, S_ALIVE, LO, "alive_early");
        expect_at(k + 2, S_DEAD,  LO, "dead_clear");
        expect_at(k + 2, S_ALIVE, HI, "alive_pulse");
        expect_at(k + 3, S_ALIVE, LO, "alive_width");
        expect_at(k + 3, S_DEAD,  LO, "dead_stays_clear");
        run(6);
        chk_pulses("alive_count", S_ALIVE, 1);

        // address pipeline, then reset mid-sequence
        bus.snes_addr_in = 24'h00FFC0;
        run(8);
        bus.snes_addr_in = 24'h7E1234;
        k = edge_n + 1;
        expect_at(k + 4, S_ADDR, 24'h00FFC0, "addr_old");
        expect_at(k + 5, S_ADDR, 24'h00FFC0 & 24'h7E1234, "addr_mix");
        expect_at(k + 6, S_ADDR, 24'h7E1234, "addr_new");
        run(8);
        snap();
        bus.snes_addr_in = 24'h123456;
        bus.snes_read_in = 1'b0;
        k = edge_n + 1;
        expect_at(k + 1, S_READ, LO, "mid_read_low");
        run(2);
        rst_n = 1'b0;
        bus.snes_cpu_clk_in = 1'b0;
        expect_at(k + 2, S_ADDR,     LO, "mid_rst_addr");
        expect_at(k + 2, S_READ,     HI, "mid_rst_read");
        expect_at(k + 2, S_CPUCLK,   LO, "mid_rst_cpu_clk");
        expect_at(k + 2, S_DEAD,     HI, "mid_rst_dead");
        expect_at(k + 2, S_FREE,     LO, "mid_rst_free");
        expect_at(k + 3, S_RD_START, LO, "mid_rst_rd_start_lost");
        run(2);
        rst_n = 1'b1;
        bus.snes_read_in = 1'b1;
        run(8);
        for (int s = 0; s < 8; s++) chk_pulses($sformatf("mid_rst_pulses_%0d", s), sig_e'(s), 0);

        chk("sb_drain", 24'(sb.size()), 24'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
